keycode_cmd_ctrl: RTL and testbench
===================================

KEYCODE_CMD_CTRL -- requirements
Module: keycode_cmd_ctrl

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 25000000, cycles from first issue to first auto-repeat (legal 2..2^25-1).
REQ-002 SHALL have parameter REPEAT_RATE, default 5000000, cycles between successive auto-repeats (legal 2..2^25-1).
REQ-003 SHALL have port Clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port keycode  in  16  SoC keycode PIO; [7:0] slot 0, [15:8] slot 1, USB HID usage codes, 0x00 = empty.
REQ-006 SHALL have port cmd_valid  out  1  command available.
REQ-007 SHALL have port cmd_ready  in  1  game logic accepts command.
REQ-008 SHALL have port cmd  out  3  command code: 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 ATTACK.
REQ-009 SHALL have port held  out  3  currently selected command (0 = none).
REQ-010 SHALL have port drop_cnt  out  8  dropped-issue counter (see Configuration).

Function
REQ-011 SHALL register keycode once (keycode_q); all decoding uses keycode_q only.
REQ-012 SHALL decode per slot: 0x1A->UP, 0x16->DOWN, 0x04->LEFT, 0x07->RIGHT, 0x2C->ATTACK, any other value->none.
REQ-013 SHALL select: ATTACK if either slot decodes ATTACK; else slot 0 decode if non-none; else slot 1 decode; else 0; held = selection, registered.
REQ-014 SHALL implement FSM IDLE, HOLD, REPEAT with 25-bit down-counter cnt.
REQ-015 IDLE: selection non-zero -> issue selection, cnt<=REPEAT_DELAY-1, go HOLD; else stay.
REQ-016 HOLD/REPEAT: selection 0 -> IDLE, no issue; selection != current command -> issue new, cnt<=REPEAT_DELAY-1, go HOLD.
REQ-017 HOLD/REPEAT with unchanged selection: cnt!=0 -> decrement; cnt==0 -> issue repeat, cnt<=REPEAT_RATE-1, go/stay REPEAT.
REQ-018 Latency: keycode change at edge k -> keycode_q at k -> cmd_valid/cmd updated at edge k+1.
REQ-019 Handshake: transfer when cmd_valid && cmd_ready; cmd SHALL stay stable while cmd_valid && !cmd_ready; cmd_valid deasserts edge after transfer unless a new issue occurs that cycle.
REQ-020 Issue with output free (cmd_valid=0, or transfer this cycle): cmd<=code, cmd_valid<=1.
REQ-021 Issue while cmd_valid=1 && cmd_ready=0: issue dropped, pending cmd unchanged, FSM/cnt still advance.
REQ-022 Release during pending cmd: pending cmd SHALL remain valid until accepted.
REQ-023 cmd_ready while cmd_valid=0 SHALL have no effect.

Reset
REQ-024 On Reset: cmd_valid=0, cmd=0, held=0, drop_cnt=0, keycode_q=0, cnt=0, state IDLE, asynchronously.
REQ-025 Reset mid-operation SHALL discard any pending command; first issue after release follows REQ-015/REQ-018.

Configuration
REQ-026 Macro KEYCMD_DROP_CNT_EN SHALL gate the drop counter.
REQ-027 Defined: drop_cnt increments by 1 on each dropped issue (REQ-021), saturating at 0xFF, cleared only by Reset.
REQ-028 Undefined: drop_cnt SHALL be constant 0 and no counter register SHALL be synthesized.

Verification (REPEAT_DELAY=8, REPEAT_RATE=4, cmd_ready=1 unless noted)
REQ-029 keycode=0x001A held 20 cycles -> cmd=1 pulses at k+1, k+9, k+13, k+17; held=1.
REQ-030 keycode=0x2C07 -> cmd=5 (ATTACK priority); then keycode=0x1607 -> cmd=4 issued immediately, delay restarted.
REQ-031 cmd_ready=0, keycode=0x0004 held 20 cycles -> cmd_valid=1, cmd=3 stable throughout; drop_cnt=3 with macro, 0 without.
REQ-032 keycode=0x0016 then 0x0000 before accept, cmd_ready=0 -> cmd=2 stays valid; cmd_ready=1 -> one transfer, then cmd_valid=0, state IDLE.
REQ-033 Reset asserted 2 cycles while in REPEAT with cmd pending -> all outputs 0 immediately; after release with keycode=0x001A -> cmd=1 two cycles later.
REQ-034 keycode=0x00FF or 0x1A00 -> 0xFF gives no command; 0x1A00 gives cmd=1 (slot 1 fallback).

Source files
------------

// File: rtl/keycode_cmd_ctrl.sv
// Keycode-to-command controller: decodes two HID keycode slots into game commands
// with auto-repeat and a valid/ready output. Optional macro KEYCMD_DROP_CNT_EN enables drop_cnt.
module keycode_cmd_ctrl #(
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] keycode,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [2:0]  cmd,
   output logic [2:0]  held,
   output logic [7:0]  drop_cnt
);

   localparam logic [2:0]  CMD_NONE   = 3'd0;
   localparam logic [2:0]  CMD_UP     = 3'd1;
   localparam logic [2:0]  CMD_DOWN   = 3'd2;
   localparam logic [2:0]  CMD_LEFT   = 3'd3;
   localparam logic [2:0]  CMD_RIGHT  = 3'd4;
   localparam logic [2:0]  CMD_ATTACK = 3'd5;
   localparam logic [24:0] DELAY_LD   = 25'(REPEAT_DELAY - 1);
   localparam logic [24:0] RATE_LD    = 25'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   function automatic logic [2:0] f_decode(input logic [7:0] code);
      logic [2:0] res;
      case (code)
         8'h1A:   res = CMD_UP;
         8'h16:   res = CMD_DOWN;
         8'h04:   res = CMD_LEFT;
         8'h07:   res = CMD_RIGHT;
         8'h2C:   res = CMD_ATTACK;
         default: res = CMD_NONE;
      endcase
      return res;
   endfunction

   logic [15:0] r_keycode_q;
   state_t      r_state;
   state_t      w_state_nxt;
   logic [24:0] r_cnt;
   logic [24:0] w_cnt_nxt;
   logic [2:0]  r_cur;
   logic [2:0]  w_cur_nxt;
   logic [2:0]  w_dec0;
   logic [2:0]  w_dec1;
   logic [2:0]  w_sel;
   logic        w_issue;
   logic        w_free;
   logic        w_xfer;
   logic        r_cmd_valid;
   logic [2:0]  r_cmd;
   logic [2:0]  r_held;

   assign w_dec0 = f_decode(r_keycode_q[7:0]);
   assign w_dec1 = f_decode(r_keycode_q[15:8]);
   assign w_xfer = r_cmd_valid & cmd_ready;
   assign w_free = ~r_cmd_valid | cmd_ready;

   // Input capture: all decoding works from this single registered copy
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_keycode_q <= 16'h0000;
      end else begin
         r_keycode_q <= keycode;
      end
   end

   // Slot arbitration: ATTACK from either slot wins, then slot 0, then slot 1
   always_comb begin
      w_sel = CMD_NONE;
      if ((w_dec0 == CMD_ATTACK) || (w_dec1 == CMD_ATTACK)) begin
         w_sel = CMD_ATTACK;
      end else if (w_dec0 != CMD_NONE) begin
         w_sel = w_dec0;
      end else begin
         w_sel = w_dec1;
      end
   end

   // FSM state, repeat counter and currently-held command registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 25'd0;
         r_cur   <= CMD_NONE;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cur   <= w_cur_nxt;
      end
   end

   // FSM next-state: first issue, delay, then periodic auto-repeat
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cur_nxt   = r_cur;
      w_issue     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_sel != CMD_NONE) begin
               w_issue     = 1'b1;
               w_cur_nxt   = w_sel;
               w_cnt_nxt   = DELAY_LD;
               w_state_nxt = ST_HOLD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_HOLD, ST_REPEAT: begin
            if (w_sel == CMD_NONE) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 25'd0;
               w_cur_nxt   = CMD_NONE;
            end else if (w_sel != r_cur) begin
               w_issue     = 1'b1;
               w_cur_nxt   = w_sel;
               w_cnt_nxt   = DELAY_LD;
               w_state_nxt = ST_HOLD;
            end else if (r_cnt != 25'd0) begin
               w_cnt_nxt   = r_cnt - 25'd1;
            end else begin
               w_issue     = 1'b1;
               w_cnt_nxt   = RATE_LD;
               w_state_nxt = ST_REPEAT;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 25'd0;
            w_cur_nxt   = CMD_NONE;
         end
      endcase
   end

   // Output handshake: an issue only lands when the output slot is free
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_cmd_valid <= 1'b0;
         r_cmd       <= CMD_NONE;
         r_held      <= CMD_NONE;
      end else begin
         r_held <= w_sel;
         if (w_issue && w_free) begin
            r_cmd_valid <= 1'b1;
            r_cmd       <= w_sel;
         end else if (w_xfer) begin
            r_cmd_valid <= 1'b0;
         end else begin
            r_cmd_valid <= r_cmd_valid;
         end
      end
   end

`ifdef KEYCMD_DROP_CNT_EN
   logic [7:0] r_drop_cnt;

   // Saturating count of issues lost to back-pressure
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_drop_cnt <= 8'h00;
      end else if (w_issue && !w_free && (r_drop_cnt != 8'hFF)) begin
         r_drop_cnt <= r_drop_cnt + 8'h01;
      end else begin
         r_drop_cnt <= r_drop_cnt;
      end
   end

   assign drop_cnt = r_drop_cnt;
`else
   assign drop_cnt = 8'h00;
`endif

   assign cmd_valid = r_cmd_valid;
   assign cmd       = r_cmd;
   assign held      = r_held;

endmodule

// File: tb/tb_keycode_cmd_ctrl.sv
// Directed bench for keycode_cmd_ctrl with REPEAT_DELAY=8, REPEAT_RATE=4.
module tb_keycode_cmd_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] keycode;
   logic        cmd_ready;
   logic        cmd_valid;
   logic [2:0]  cmd;
   logic [2:0]  held;
   logic [7:0]  drop_cnt;

   int n_checks = 0;
   int n_errors = 0;
   int exp_drop;

   typedef struct {
      logic [15:0] kc;
      logic        rdy;
      logic        ev;
      logic [2:0]  ec;
      logic [2:0]  eh;
   } vec_t;

   vec_t vecs[20];

   always #5 Clk = ~Clk;

   keycode_cmd_ctrl #(.REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (
      .Clk(Clk), .Reset(Reset), .keycode(keycode), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .cmd(cmd), .held(held), .drop_cnt(drop_cnt)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [15:0] kc, input logic rdy, input logic ev,
                               input logic [2:0] ec, input logic [2:0] eh);
      vec_t v;
      v.kc = kc; v.rdy = rdy; v.ev = ev; v.ec = ec; v.eh = eh;
      return v;
   endfunction

   initial begin
      // inputs applied before an edge, outputs expected just after it
      vecs[0]  = mk(16'h0000, 1'b1, 1'b0, 3'd0, 3'd0);
      vecs[1]  = mk(16'h001A, 1'b1, 1'b0, 3'd0, 3'd0);
      vecs[2]  = mk(16'h001A, 1'b1, 1'b1, 3'd1, 3'd1);
      vecs[3]  = mk(16'h0000, 1'b1, 1'b0, 3'd1, 3'd1);
      vecs[4]  = mk(16'h0000, 1'b1, 1'b0, 3'd1, 3'd0);
      vecs[5]  = mk(16'h2C07, 1'b1, 1'b0, 3'd1, 3'd0);
      vecs[6]  = mk(16'h2C07, 1'b1, 1'b1, 3'd5, 3'd5);
      vecs[7]  = mk(16'h1607, 1'b1, 1'b0, 3'd5, 3'd5);
      vecs[8]  = mk(16'h1607, 1'b1, 1'b1, 3'd4, 3'd4);
      vecs[9]  = mk(16'h00FF, 1'b1, 1'b0, 3'd4, 3'd4);
      vecs[10] = mk(16'h1A00, 1'b1, 1'b0, 3'd4, 3'd0);
      vecs[11] = mk(16'h1A00, 1'b1, 1'b1, 3'd1, 3'd1);
      vecs[12] = mk(16'h0000, 1'b1, 1'b0, 3'd1, 3'd1);
      vecs[13] = mk(16'h0000, 1'b1, 1'b0, 3'd1, 3'd0);
      vecs[14] = mk(16'h0016, 1'b0, 1'b0, 3'd1, 3'd0);
      vecs[15] = mk(16'h0016, 1'b0, 1'b1, 3'd2, 3'd2);
      vecs[16] = mk(16'h0000, 1'b0, 1'b1, 3'd2, 3'd2);
      vecs[17] = mk(16'h0000, 1'b0, 1'b1, 3'd2, 3'd0);
      vecs[18] = mk(16'h0000, 1'b1, 1'b0, 3'd2, 3'd0);
      vecs[19] = mk(16'h0000, 1'b1, 1'b0, 3'd2, 3'd0);

      Reset     = 1'b1;
      keycode   = 16'h0000;
      cmd_ready = 1'b1;
      #12;
      check("rst_valid", int'(cmd_valid), 0);
      check("rst_cmd", int'(cmd), 0);
      check("rst_held", int'(held), 0);
      check("rst_drop", int'(drop_cnt), 0);
      @(posedge Clk);
      #1 Reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         keycode   = vecs[i].kc;
         cmd_ready = vecs[i].rdy;
         tick();
         check($sformatf("v%0d_valid", i), int'(cmd_valid), int'(vecs[i].ev));
         check($sformatf("v%0d_cmd", i), int'(cmd), int'(vecs[i].ec));
         check($sformatf("v%0d_held", i), int'(held), int'(vecs[i].eh));
      end

      // auto-repeat timing: pulses at k+1, k+9, k+13, k+17
      keycode   = 16'h001A;
      cmd_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("rep%0d_valid", i), int'(cmd_valid),
               (i == 1 || i == 9 || i == 13 || i == 17) ? 1 : 0);
         if (i >= 1) check($sformatf("rep%0d_held", i), int'(held), 1);
         if (cmd_valid) check($sformatf("rep%0d_cmd", i), int'(cmd), 1);
      end
      keycode = 16'h0000;
      tick();
      tick();
      check("rep_end_valid", int'(cmd_valid), 0);

      // back-pressure: pending LEFT stays stable, repeats are dropped
      keycode   = 16'h0004;
      cmd_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("bp%0d_valid", i), int'(cmd_valid), (i >= 1) ? 1 : 0);
         if (i >= 1) check($sformatf("bp%0d_cmd", i), int'(cmd), 3);
      end
`ifdef KEYCMD_DROP_CNT_EN
      exp_drop = 3;
`else
      exp_drop = 0;
`endif
      check("bp_drop", int'(drop_cnt), exp_drop);
      keycode = 16'h0000;
      tick();
      tick();
      check("bp_rel_valid", int'(cmd_valid), 1);
      check("bp_rel_cmd", int'(cmd), 3);
      check("bp_rel_held", int'(held), 0);
      cmd_ready = 1'b1;
      tick();
      check("bp_acc_valid", int'(cmd_valid), 0);
      tick();
      check("bp_idle_valid", int'(cmd_valid), 0);

      // reset while in REPEAT with a command pending
      keycode   = 16'h001A;
      cmd_ready = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      check("pre_rst_valid", int'(cmd_valid), 1);
      check("pre_rst_cmd", int'(cmd), 1);
`ifdef KEYCMD_DROP_CNT_EN
      exp_drop = 4;
`else
      exp_drop = 0;
`endif
      check("pre_rst_drop", int'(drop_cnt), exp_drop);
      #2 Reset = 1'b1;
      #1;
      check("mid_rst_valid", int'(cmd_valid), 0);
      check("mid_rst_cmd", int'(cmd), 0);
      check("mid_rst_held", int'(held), 0);
      check("mid_rst_drop", int'(drop_cnt), 0);
      cmd_ready = 1'b1;
      @(posedge Clk);
      @(posedge Clk);
      #1 Reset = 1'b0;
      tick();
      check("post_rst1_valid", int'(cmd_valid), 0);
      tick();
      check("post_rst2_valid", int'(cmd_valid), 1);
      check("post_rst2_cmd", int'(cmd), 1);
      check("post_rst2_held", int'(held), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
